// File: rtl/seq_alu.sv
// Registered multi-function ALU with start/done handshake and ZERO/NEG/CARRY/OVF flags.
// Define SEQ_ALU_MUL_EN to build in the multi-cycle shift-and-add multiplier (op 110).
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOP,
  input  logic [WIDTH-1:0] readReg1,
  input  logic [WIDTH-1:0] readReg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultALU,
  output logic             ZERO,
  output logic             NEG,
  output logic             CARRY,
  output logic             OVF
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b111;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [2:0]  OP_MUL   = 3'b110;
  localparam int unsigned AW       = 2 * WIDTH;
  localparam int unsigned CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    mul_sum;
`endif

  // Result and flags of every single-cycle op, straight from the operand inputs.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sum      = {1'b0, readReg1} + {1'b0, readReg2};
    diff     = {1'b0, readReg1} - {1'b0, readReg2};
    case (ALUOP)
      OP_NOP: ;
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (readReg1[WIDTH-1] == readReg2[WIDTH-1]) &&
                   (sum[WIDTH-1] != readReg1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (readReg1[WIDTH-1] != readReg2[WIDTH-1]) &&
                   (diff[WIDTH-1] != readReg1[WIDTH-1]);
      end
      OP_NAND: sc_res = ~(readReg1 & readReg2);
      OP_SHL: begin
        sc_res   = {readReg1[WIDTH-2:0], 1'b0};
        sc_carry = readReg1[WIDTH-1];
      end
      OP_SHR: begin
        sc_res   = {1'b0, readReg1[WIDTH-1:1]};
        sc_carry = readReg1[0];
      end
      OP_ASR: begin
        sc_res   = {readReg1[WIDTH-1], readReg1[WIDTH-1:1]};
        sc_carry = readReg1[0];
      end
      default: ;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (ALUOP == OP_MUL)) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
`endif

  // Datapath next values; flags move only together with done.
  always_comb begin
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    busy_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == S_MUL) begin
      busy_d   = 1'b1;
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        res_d   = mul_sum[WIDTH-1:0];
        carry_d = |mul_sum[AW-1:WIDTH];
        ovf_d   = 1'b0;
      end
    end else
`endif
    if (start) begin
`ifdef SEQ_ALU_MUL_EN
      if (ALUOP == OP_MUL) begin
        busy_d   = 1'b1;
        acc_d    = '0;
        mcand_d  = AW'(readReg1);
        mplier_d = readReg2;
        cnt_d    = '0;
      end else
`endif
      begin
        res_d   = sc_res;
        carry_d = sc_carry;
        ovf_d   = sc_ovf;
        done_d  = 1'b1;
      end
    end
    if (done_d) begin
      zero_d = (res_d == '0);
      neg_d  = res_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign done      = done_q;
  assign resultALU = res_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign CARRY     = carry_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8); multiply checks follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

  localparam int unsigned W = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   ALUOP;
  logic [W-1:0] readReg1;
  logic [W-1:0] readReg2;
  logic         busy;
  logic         done;
  logic [W-1:0] resultALU;
  logic         ZERO;
  logic         NEG;
  logic         CARRY;
  logic         OVF;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOP(ALUOP),
    .readReg1(readReg1), .readReg2(readReg2),
    .busy(busy), .done(done), .resultALU(resultALU),
    .ZERO(ZERO), .NEG(NEG), .CARRY(CARRY), .OVF(OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    e.c = 1'b0;
    e.o = 1'b0;
    case (op)
      OP_ADD: begin
        r = ua + ub;
        e.c = (r > 255);
        s = sa + sb;
        e.o = (s > 127) || (s < -128);
      end
      OP_SUB: begin
        r = ua - ub;
        e.c = (ua < ub);
        s = sa - sb;
        e.o = (s > 127) || (s < -128);
      end
      OP_NAND: r = int'(~(a & b));
      OP_SHL: begin
        r = ua * 2;
        e.c = a[W-1];
      end
      OP_SHR: begin
        r = ua / 2;
        e.c = a[0];
      end
      OP_ASR: begin
        r = sa >>> 1;
        e.c = a[0];
      end
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: begin
        r = ua * ub;
        e.c = (r > 255);
      end
`endif
      default: r = 0;
    endcase
    e.r = W'(r);
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Every done pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 32'(resultALU), 32'(e.r));
        chk("flags_zncv", 32'({ZERO, NEG, CARRY, OVF}), 32'({e.z, e.n, e.c, e.o}));
      end
    end
  end

  task automatic op1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    ALUOP = op;
    readReg1 = a;
    readReg2 = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    chk("done_1cyc", 32'(done), 32'd1);
    chk("busy_1cyc", 32'(busy), 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_drop", 32'(done), 32'd0);
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int lat;
    int busy_n;
    @(negedge clk);
    start = 1'b1;
    ALUOP = OP_MUL;
    readReg1 = a;
    readReg2 = b;
    sb_q.push_back(model(OP_MUL, a, b));
    @(posedge clk);
    #1;
    lat = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      start = poke && (lat == 3);
      ALUOP = OP_ADD;
      readReg1 = 8'h01;
      readReg2 = 8'h01;
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) busy_n++;
    end
    chk("mul_latency", 32'(lat), 32'd8);
    chk("mul_busy_cycles", 32'(busy_n), 32'd8);
    chk("mul_busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic mul_reset();
    @(negedge clk);
    start = 1'b1;
    ALUOP = OP_MUL;
    readReg1 = 8'h0C;
    readReg2 = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mul", 32'({busy, done, resultALU, ZERO, NEG, CARRY, OVF}), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", 32'({busy, done}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", 32'({busy, done}), 32'd0);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    rst = 1'b1;
    start = 1'b0;
    ALUOP = OP_NOP;
    readReg1 = '0;
    readReg2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, resultALU, ZERO, NEG, CARRY, OVF}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op1(OP_ADD, 8'h7F, 8'h01);
    idle();
    op1(OP_SUB, 8'h05, 8'h05);
    op1(OP_SUB, 8'h03, 8'h05);
    idle();
    op1(OP_SHL, 8'h81, 8'h00);
    op1(OP_SHR, 8'h81, 8'h00);
    op1(OP_ASR, 8'h81, 8'h00);
    op1(OP_NAND, 8'h81, 8'hFF);
    op1(OP_NOP, 8'h12, 8'h34);
    idle();

`ifdef SEQ_ALU_MUL_EN
    mul(8'h0C, 8'h0B, 1'b1);
    idle();
    mul(8'h10, 8'h10, 1'b0);
    idle();
    mul_reset();
`else
    op1(OP_MUL, 8'h0C, 8'h0B);
    idle();
`endif

    op1(OP_ADD, 8'h02, 8'h03);
    idle();

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
`ifdef SEQ_ALU_MUL_EN
      if (rop == OP_MUL) rop = OP_SUB;
`endif
      op1(rop, 8'($urandom), 8'($urandom));
    end
    idle();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the processor's 8-bit ALU. Accepts an operation and two operands through a start/done handshake, performs add, subtract, NAND, logical/arithmetic shifts and an optional multi-cycle shift-and-add multiply, and presents the registered result with ZERO, NEG, CARRY and OVF flags. It sits between the register-file read ports and the write-back/branch logic. The datapath controller stalls on `busy`.

## Interface
- `WIDTH`, 8, operand/result width in bits; minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on the rising edge while idle.
- `ALUOP`  in  3  operation code, sampled with `start`.
- `readReg1`  in  WIDTH  operand A, signed.
- `readReg2`  in  WIDTH  operand B, signed.
- `busy`  out  1  multiply in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse; result and flags updated this cycle.
- `resultALU`  out  WIDTH  registered result; holds until the next completion.
- `ZERO`  out  1  result == 0.
- `NEG`  out  1  result[WIDTH-1].
- `CARRY`  out  1  carry, borrow or shifted-out bit (per op).
- `OVF`  out  1  signed overflow (ADD/SUB only).

## Operation
- States: IDLE, MUL. Operands and opcode are latched when `start` is accepted, so later input changes are ignored.
- 000 NOP: result 0, ZERO=1, CARRY=0, OVF=0.
- 001 ADD: A+B mod 2^WIDTH; CARRY = unsigned carry-out; OVF = signed overflow.
- 010 SUB: A−B; CARRY = borrow (A<B unsigned); OVF = signed overflow.
- 011 NAND: ~(A&B); CARRY=0, OVF=0.
- 100 SHL: A<<1; CARRY = A[WIDTH-1]; OVF=0.
- 101 SHR (logical): A>>1; CARRY = A[0]; OVF=0.
- 110 MUL: low WIDTH bits of unsigned A×B; CARRY = 1 if the high half is nonzero; OVF=0. Computed with 1 bit of B per cycle over WIDTH iterations, using an internal 2×WIDTH accumulator and a $clog2(WIDTH)-bit counter.
- 111 ASR: arithmetic A>>>1; CARRY = A[0]; OVF=0.
- ZERO and NEG are always derived from the final result, for every op. All four flags update only together with `done`.
- IDLE→MUL: `start` accepted with op 110. MUL→IDLE: after the WIDTH-th iteration.

## Timing
- Reset values: `resultALU`=0, ZERO=NEG=CARRY=OVF=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Single-cycle ops: `start` accepted at edge E0; `done`=1 and result valid after E0; `done` clears after E1 unless a new op is accepted at E1.
- MUL: `busy`=1 after E0 through E(WIDTH−1), i.e. WIDTH cycles. After E(WIDTH): `busy`=0, `done`=1, result valid.
- A `start` in the cycle where `done` is high is accepted, so back-to-back single-cycle ops give `done` high continuously.
- `start` while `busy`=1 is dropped; no queueing.
- Reset mid-MUL aborts the operation: all outputs return to reset values and no `done` is produced.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL state, accumulator and counter are compiled in; op 110 behaves as above.
- Not defined: no MUL logic is compiled. Op 110 executes as NOP with 1-cycle latency, `busy` is tied 0, and no multi-cycle state exists.

## Test plan
- Reset then ADD 0x7F+0x01 (WIDTH=8) -> 0x80, NEG=1, OVF=1, CARRY=0, ZERO=0; `done` one cycle after accept, for one cycle only.
- SUB 0x05−0x05 -> 0x00, ZERO=1, CARRY=0. Then SUB 0x03−0x05 -> 0xFE, NEG=1, CARRY=1, OVF=0, issued back-to-back with `done` high continuously.
- Operand 0x81: SHL -> 0x02, CARRY=1. SHR -> 0x40, CARRY=1. ASR -> 0xC0, NEG=1. NAND with 0xFF -> 0x7E.
- MUL 0x0C×0x0B -> 0x84, NEG=1, CARRY=0, `busy` high exactly 8 cycles, `done` 8 edges after accept. MUL 0x10×0x10 -> 0x00, ZERO=1, CARRY=1. A `start` pulsed mid-multiply is ignored.
- Assert `rst` during the 3rd MUL iteration -> all outputs 0, no `done`. A following ADD 0x02+0x03 -> 0x05 with 1-cycle latency.
- Build without `SEQ_ALU_MUL_EN`: op 110 with 0x0C,0x0B -> result 0, ZERO=1, `busy` never high, `done` after 1 cycle.
